console_uart_tx: RTL and testbench
==================================

Name: console_uart_tx

Overview:
- Memory-mapped console transmitter for the pipeline CPU.
- The MEM stage decodes a store to the console address and pulses a one-byte write; the block buffers bytes in a small FIFO and serialises them as 8N1 UART frames on a single output line.
- It is the sending end of the character-print path: the CPU produces characters and this block transmits them to the off-chip or bench receiver.
- It exports full/busy status so software can poll, and so halt logic can wait for the drain before stopping.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit; must be at least 2.
- FIFO_DEPTH, 4: byte FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- wr_en  in  1  one-cycle pulse; store to console address accepted from MEM stage.
- wr_data  in  8  byte to transmit (store data[7:0]).
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- busy  out  1  FIFO non-empty OR FSM not IDLE.
- overflow  out  1  sticky: a write was dropped.
- tx  out  1  serial line; idle high.

Behaviour:
- Reset: asynchronous, active-high; takes effect immediately, mid-frame included.
  - Outputs: tx=1, full=0, busy=0, overflow=0.
  - Internal state: FIFO pointers and count=0, FSM=IDLE, baud counter=0, bit index=0.
  - Partial frames are abandoned and no bytes are retained.
- FIFO:
  - Count width is clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - Write accepted when wr_en AND (count<FIFO_DEPTH OR pop in the same cycle).
  - Simultaneous push and pop: count unchanged, both pointers advance. This also applies when full, so the write is accepted.
  - Pop while empty never occurs.
  - Write refused: byte discarded, overflow set to 1; overflow is cleared only by rst.
  - full and busy are combinational from registered state.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count>0: pop the head byte into the 8-bit shift register, baud counter=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index=0.
  - DATA: tx=shift[0] (LSB first). Each bit lasts CLKS_PER_BIT cycles, then shift right and increment the index. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if count>0, pop and go directly to START (no idle gap); otherwise go to IDLE.
  - Baud counter runs 0..CLKS_PER_BIT-1 and the bit period ends at terminal count.
- tx is a registered output (no glitches).
- Latency:
  - Write accepted at edge E0 into an empty FIFO with FSM in IDLE: the FIFO shows count=1 after E0.
  - At edge E1 the FSM pops and enters START, so tx falls after E1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back bytes: frames are contiguous and the stop bit is followed immediately by the next start bit.
- A wr_en arriving during any frame state only enqueues; it never disturbs the frame in flight.
- busy stays 1 from the cycle after an accepted write until the STOP of the last byte completes; it drops at the same edge the FSM returns to IDLE.

Decomposition:
- Shared package/define file holds:
  - FSM state encoding: TX_IDLE=2'd0, TX_START=2'd1, TX_DATA=2'd2, TX_STOP=2'd3.
  - Console MMIO address constant (decoded outside this block).
  - Default CLKS_PER_BIT.
- One sub-module: sync_fifo, parameterised width 8 and depth FIFO_DEPTH, with push/pop/count/full/empty.
- The top holds the FSM, baud counter, shift register and overflow flag.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset then single write 0x41: tx holds 1 until E1, then emits 0,1,0,0,0,0,0,1,0,1 with each bit 4 cycles (40 cycles total). busy=1 throughout the frame, 0 after; overflow=0.
- Write 0x48, 0x69 on consecutive cycles: two contiguous 40-cycle frames with no idle cycle between stop and start; receiver model decodes "Hi".
- Six writes on consecutive cycles while idle:
  - The first byte pops at E1; full asserts after the 5th write.
  - The 6th write is dropped, so overflow=1 stays set.
  - Exactly 5 frames are transmitted (bytes 1-5).
- FIFO full and STOP ends in the same cycle as wr_en=0x5A: the write is accepted, overflow stays 0, and 0x5A is transmitted last.
- Assert rst mid-DATA (bit 3 of 0x55) with 2 bytes queued: tx=1 immediately (asynchronous), busy=0, full=0, overflow=0. No further frames follow until a new write.
- Random writes vs. the bench UART receiver model for 200 bytes with random gaps: decoded stream equals the accepted byte sequence; overflow matches the model's drop count >0.

Source files
------------

// File: rtl/console_uart_tx_pkg.sv
// Shared definitions for the console transmitter: FSM encoding, MMIO address, baud default.
package console_uart_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Store address the MEM stage decodes into a wr_en pulse.
  localparam logic [31:0] CONSOLE_ADDR = 32'hFFFF_FFF0;

  localparam int DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/console_uart_tx_sync_fifo.sv
// Byte FIFO for the console path; head byte is visible combinationally on dout_o.
// Caller must not push when full without a same-cycle pop, nor pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/console_uart_tx.sv
// Console transmitter: buffers CPU store bytes and sends them as contiguous 8N1 frames on tx.
// Writes into a full FIFO are dropped (sticky overflow) unless the FSM pops that same cycle.
module console_uart_tx
  import console_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          baud_last, have_byte;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (wr_data),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign baud_last = (baud_q == BAUD_LAST);
  assign have_byte = (fifo_count != '0);
  // A full FIFO still accepts when the FSM frees a slot in the same cycle.
  assign fifo_push = wr_en && (!fifo_full || fifo_pop);
  assign ovf_d     = ovf_q | (wr_en & ~fifo_push);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (have_byte) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (baud_last) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = TX_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (have_byte) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // tx follows the next state so the line changes on the same edge as the FSM.
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign full     = fifo_full;
  assign busy     = !fifo_empty || (state_q != TX_IDLE);
  assign overflow = ovf_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed and table-driven bench for console_uart_tx with a serial receiver model.
module tb_console_uart_tx;

  localparam int CPB   = 4;
  localparam int DEP   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, busy, overflow, tx;

  int checks = 0;
  int errors = 0;

  console_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Receiver model: start detected at the first low sample, each bit sampled one cycle into its period.
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic       rx_act = 1'b0;
  int         rx_ph = 0;
  logic [7:0] rx_sh = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_ph  = 0;
      end
    end else begin
      rx_ph++;
      if (rx_ph >= CPB + 1 && rx_ph <= 8 * CPB + 1 && ((rx_ph - 1) % CPB) == 0) begin
        int bi;
        bi = (rx_ph - 1) / CPB - 1;
        rx_sh[bi] = tx;
      end
      if (rx_ph == 9 * CPB + 1) begin
        chk("rx_stop_bit", {31'd0, tx}, 32'd1);
        rx_q.push_back(rx_sh);
        rx_act = 1'b0;
      end
    end
  end

  // Called at a falling edge: drive inputs, take one rising edge, return at the next falling edge.
  task automatic tick(input logic w, input logic [7:0] d);
    wr_en   = w;
    wr_data = d;
    @(posedge clk);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick(1'b0, 8'h00);
      n++;
    end
    chk("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_rx(input string nm);
    int n;
    chk({nm, "_rx_len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_rx%0d", nm, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       e_tx;
    logic       e_busy;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t vt[45];

  // Random-phase model state
  int m_cnt, m_rem, drops;
  logic m_idle;

  task automatic model_step(input logic w, input logic [7:0] d);
    logic pop, acc;
    pop = 1'b0;
    if (m_idle) begin
      if (m_cnt > 0) begin
        pop    = 1'b1;
        m_idle = 1'b0;
        m_rem  = FRAME;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_cnt > 0) begin
          pop   = 1'b1;
          m_rem = FRAME;
        end else begin
          m_idle = 1'b1;
        end
      end
    end
    acc = w && (m_cnt < DEP || pop);
    if (acc) exp_q.push_back(d);
    else if (w) drops++;
    m_cnt = m_cnt + int'(acc) - int'(pop);
    tick(w, d);
    chk("t6_busy", {31'd0, busy}, {31'd0, (m_cnt > 0) || !m_idle});
  endtask

  initial begin
    logic [9:0] f41;
    int n;

    // 0x41 on the line, first-sent bit in bit 0: start, 1,0,0,0,0,0,1,0, stop
    f41 = 10'b1010000010;
    vt[0] = '{1'b1, 8'h41, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 1; k <= 40; k++) vt[k] = '{1'b0, 8'h00, f41[(k - 1) / 4], 1'b1, 1'b0, 1'b0};
    for (int k = 41; k < 45; k++) vt[k] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

    @(negedge clk);
    do_reset();
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_ovf", {31'd0, overflow}, 32'd0);

    // Single byte, cycle-exact
    for (int i = 0; i < 45; i++) begin
      tick(vt[i].wr, vt[i].d);
      chk($sformatf("t1_vec%0d_tx_busy_full_ovf", i), {28'd0, tx, busy, full, overflow},
          {28'd0, vt[i].e_tx, vt[i].e_busy, vt[i].e_full, vt[i].e_ovf});
    end
    exp_q = '{8'h41};
    chk_rx("t1");

    // Two back-to-back bytes: busy spans exactly 1 + 2 frames of cycles
    n = 0;
    tick(1'b1, 8'h48);
    if (busy) n++;
    tick(1'b1, 8'h69);
    if (busy) n++;
    while (busy && n < 300) begin
      tick(1'b0, 8'h00);
      if (busy) n++;
    end
    chk("t2_busy_cycles", n, 1 + 2 * FRAME);
    chk("t2_ovf", {31'd0, overflow}, 32'd0);
    exp_q = '{8'h48, 8'h69};
    chk_rx("t2");

    // Six writes: fifth fills, sixth dropped
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 8'hC0 + 8'(i));
      if (i == 3) chk("t3_full_after4", {31'd0, full}, 32'd0);
      if (i == 4) chk("t3_full_after5", {30'd0, full, overflow}, 32'b10);
      if (i == 5) chk("t3_after6", {30'd0, full, overflow}, 32'b11);
    end
    drain(8 * FRAME);
    chk("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
    exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    chk_rx("t3");

    // Write while full on the exact cycle STOP ends
    do_reset();
    chk("t4_reset_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h10 + 8'(i));
    chk("t4_full", {30'd0, full, overflow}, 32'b10);
    for (int i = 0; i < 36; i++) tick(1'b0, 8'h00);
    chk("t4_stop_full", {30'd0, tx, full}, 32'b11);
    tick(1'b1, 8'h5A);
    chk("t4_accept_full_ovf", {30'd0, full, overflow}, 32'b10);
    drain(8 * FRAME);
    chk("t4_ovf_end", {31'd0, overflow}, 32'd0);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h5A};
    chk_rx("t4");

    // Asynchronous reset during bit 3 of 0x55 with two bytes queued
    do_reset();
    tick(1'b1, 8'h55);
    tick(1'b1, 8'hA1);
    tick(1'b1, 8'hA2);
    for (int i = 0; i < 16; i++) tick(1'b0, 8'h00);
    chk("t5_pre_tx_busy_full", {29'd0, tx, busy, full}, 32'b010);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_outs", {28'd0, tx, busy, full, overflow}, 32'b1000);
    @(negedge clk);
    tick(1'b0, 8'h00);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 8'h00);
      if (tx !== 1'b1) n++;
    end
    chk("t5_line_quiet", n, 0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk_rx("t5");

    // Random writes against a timing model of the FIFO and frame cadence
    do_reset();
    m_cnt  = 0;
    m_rem  = 0;
    m_idle = 1'b1;
    drops  = 0;
    for (int b = 0; b < 200; b++) begin
      int gap;
      model_step(1'b1, 8'($urandom_range(0, 255)));
      gap = $urandom_range(0, 50);
      for (int g = 0; g < gap; g++) model_step(1'b0, 8'h00);
    end
    drain(8 * FRAME);
    chk("t6_drops_nonzero", {31'd0, drops > 0}, 32'd1);
    chk("t6_ovf", {31'd0, overflow}, {31'd0, drops > 0});
    chk_rx("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
